// File: rtl/div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_share_ctrl
// Purpose  : Shares one iterative signed divider between two requesters.
//            Round-robin grant, operand latch, start/busy handshake to the
//            divider, divide-by-zero short-circuit, tagged one-cycle result.
// Revision : 1.0  initial release
// ============================================================================
module div_share_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_dividend,
  input  logic [WIDTH-1:0] req0_divisor,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_dividend,
  input  logic [WIDTH-1:0] req1_divisor,
  output logic             req1_ready,
  output logic             out_valid,
  output logic             out_id,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_r,
  output logic             out_dz,
  output logic             div_reset,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_last_grant;
  logic             r_id;
  logic             r_dz;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;

  logic             w_grant_any;
  logic             w_grant_id;
  logic [WIDTH-1:0] w_win_dividend;
  logic [WIDTH-1:0] w_win_divisor;
  logic             w_win_dz;
  logic             w_req0_ready;
  logic             w_req1_ready;
  logic             w_accept;
  logic             w_div_start;
  logic             w_out_valid;
  logic             w_load_result;

  // Round-robin grant: a lone request wins outright; on a tie the requester
  // that did not win last time is chosen.
  always_comb begin
    w_grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      w_grant_id = ~r_last_grant;
    end else begin
      w_grant_id = req1_valid;
    end
    w_win_dividend = w_grant_id ? req1_dividend : req0_dividend;
    w_win_divisor  = w_grant_id ? req1_divisor  : req0_divisor;
    w_win_dz       = (w_win_divisor == '0);
  end

  // Next-state and decoded outputs. Ready is additionally gated by reset so
  // that no requester sees an accept while the controller is held in reset.
  always_comb begin
    w_state_nxt  = r_state;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_div_start  = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req0_ready = reset & w_grant_any & ~w_grant_id;
        w_req1_ready = reset & w_grant_any &  w_grant_id;
        if (w_grant_any) begin
          w_state_nxt = w_win_dz ? S_DONE : S_START;
        end
      end
      S_START: begin
        w_div_start = 1'b1;
        w_state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (div_busy) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!div_busy) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_accept      = w_req0_ready | w_req1_ready;
  assign w_load_result = (r_state == S_RUN) & ~div_busy;

  // State register; reset aborts any in-flight division back to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand latch and grant history, updated only on the accept edge so the
  // divider sees stable operands until the next accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_dividend   <= '0;
      r_divisor    <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant_id;
      r_id         <= w_grant_id;
      r_dividend   <= w_win_dividend;
      r_divisor    <= w_win_divisor;
    end
  end

  // Result registers: zero-divisor substitute on accept, divider result when
  // busy falls in RUN. They hold their value between results.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q  <= '0;
      r_r  <= '0;
      r_dz <= 1'b0;
    end else if (w_accept && w_win_dz) begin
      r_q  <= '1;
      r_r  <= w_win_dividend;
      r_dz <= 1'b1;
    end else if (w_load_result) begin
      r_q  <= div_q;
      r_r  <= div_r;
      r_dz <= 1'b0;
    end
  end

  assign req0_ready   = w_req0_ready;
  assign req1_ready   = w_req1_ready;
  assign div_start    = w_div_start;
  assign out_valid    = w_out_valid;
  assign out_id       = r_id;
  assign out_q        = r_q;
  assign out_r        = r_r;
  assign out_dz       = r_dz;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;
  assign div_reset    = ~reset;

endmodule
`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_share_ctrl
// Purpose  : Self-checking bench for div_share_ctrl with a behavioural divider.
// Revision : 1.0  initial release
// ============================================================================
module tb_div_share_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_id, out_dz;
  logic [31:0] out_q, out_r;
  logic        div_reset, div_start, div_busy;
  logic [31:0] div_dividend, div_divisor, div_q, div_r;

  logic        m_busy;
  logic        busy_glitch;
  int          m_lat;
  int          m_cnt;
  logic signed [31:0] m_a, m_b;

  int checks = 0;
  int errors = 0;
  bit tb_last;

  always #5 clock = ~clock;

  div_share_ctrl #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_dividend(req0_dividend), .req0_divisor(req0_divisor), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_dividend(req1_dividend), .req1_divisor(req1_divisor), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_id(out_id), .out_q(out_q), .out_r(out_r), .out_dz(out_dz),
    .div_reset(div_reset), .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_q(div_q), .div_r(div_r)
  );

  // Behavioural divider: busy rises the cycle after start and stays high m_lat cycles.
  assign div_busy = m_busy | busy_glitch;
  always @(posedge clock or posedge div_reset) begin
    if (div_reset) begin
      m_busy <= 1'b0; m_cnt <= 0; div_q <= '0; div_r <= '0;
    end else if (div_start && !m_busy) begin
      m_a <= div_dividend; m_b <= div_divisor; m_cnt <= m_lat; m_busy <= 1'b1;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        div_q  <= m_a / m_b;
        div_r  <= m_a % m_b;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference arithmetic: truncating signed division, zero divisor substitute.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output bit dz);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); dz = 1'b0;
    end
  endfunction

  // Monitors: start pulse width, ready exclusivity, operand stability in flight.
  bit          prev_start = 1'b0;
  bit          inflight = 1'b0;
  logic [31:0] hold_a, hold_b;

  always @(posedge clock or negedge reset) begin
    if (!reset) inflight = 1'b0;
    else if (out_valid) inflight = 1'b0;
    else if (req0_valid && req0_ready) begin
      hold_a = req0_dividend; hold_b = req0_divisor; inflight = 1'b1;
    end else if (req1_valid && req1_ready) begin
      hold_a = req1_dividend; hold_b = req1_divisor; inflight = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (div_start) chk("start_width_prev", 32'(prev_start), 32'd0);
    prev_start = div_start;
    if (req0_ready || req1_ready) chk("ready_excl", 32'(req0_ready & req1_ready), 32'd0);
    if (inflight && reset) begin
      chk("hold_dividend", div_dividend, hold_a);
      chk("hold_divisor", div_divisor, hold_b);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; busy_glitch = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1; tb_last = 1'b1;
  endtask

  // One transaction: present requests, wait for the accept, then measure the
  // result latency and start count. Called at a negedge; returns at a negedge.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input int lat, input bit exp_win,
                         output bit id, output logic [31:0] q, output logic [31:0] r, output bit dz);
    int n; int k; int starts; bit got; bit exp_dz;
    id = 1'b0; q = '0; r = '0; dz = 1'b0;
    m_lat = lat;
    req0_valid = v0; req0_dividend = a0; req0_divisor = b0;
    req1_valid = v1; req1_dividend = a1; req1_divisor = b1;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(negedge clock); #1; n++;
    end
    if (!(req0_ready || req1_ready)) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clock);
      return;
    end
    chk("grant", 32'(req1_ready), 32'(exp_win));
    exp_dz = ((exp_win ? b1 : b0) == 32'd0);
    @(posedge clock);
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    starts = 0; got = 1'b0;
    for (k = 1; k <= 200; k++) begin
      if (k > 1) @(negedge clock);
      if (div_start) starts++;
      if (out_valid) begin
        got = 1'b1; id = out_id; q = out_q; r = out_r; dz = out_dz;
        break;
      end
    end
    if (!got) begin
      chk("result_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", 32'(k), exp_dz ? 32'd1 : 32'(3 + lat));
    chk("start_count", 32'(starts), exp_dz ? 32'd0 : 32'd1);
    @(negedge clock);
    chk("valid_pulse", 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    bit          id;
    logic [31:0] a, b, q, r;
    bit          dz;
    int          lat;
  } vec_t;

  vec_t tv[8];

  initial begin
    bit id_g; bit dz_g; logic [31:0] q_g, r_g;
    logic [31:0] eq, er; bit edz;
    int ids[4]; logic [31:0] qs[4], rs[4]; int nres; bit seen;

    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit id_g; bit dz_g; logic [31:0] q_g, r_g;
    logic [31:0] eq, er; bit edz;
    int ids[4]; logic [31:0] qs[4], rs[4]; int nres; bit seen;

    tv[0] = '{1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 4};
    tv[1] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0, 2};
    tv[2] = '{1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 3};
    tv[3] = '{1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1};
    tv[4] = '{1'b0, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 5};
    tv[5] = '{1'b1, 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         1'b0, 3};
    tv[6] = '{1'b1, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         1'b1, 2};
    tv[7] = '{1'b0, 32'd0,         32'd9,         32'd0,         32'd0,         1'b0, 6};

    // Reset state, with both requests asserted to prove ready stays low.
    reset = 1'b0; busy_glitch = 1'b0; m_lat = 3; tb_last = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_dividend = 32'd1; req0_divisor = 32'd1; req1_dividend = 32'd2; req1_divisor = 32'd2;
    @(negedge clock); #1;
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_out_q", out_q, 32'd0);
    chk("rst_out_r", out_r, 32'd0);
    chk("rst_out_dz", 32'(out_dz), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_div_dividend", div_dividend, 32'd0);
    chk("rst_div_divisor", div_divisor, 32'd0);
    chk("rst_div_reset", 32'(div_reset), 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Table-driven single-requester vectors.
    for (int i = 0; i < 8; i++) begin
      run_txn(!tv[i].id, tv[i].id, tv[i].a, tv[i].b, tv[i].a, tv[i].b, tv[i].lat, tv[i].id,
              id_g, q_g, r_g, dz_g);
      tb_last = tv[i].id;
      chk($sformatf("tv%0d_id", i), 32'(id_g), 32'(tv[i].id));
      chk($sformatf("tv%0d_q", i), q_g, tv[i].q);
      chk($sformatf("tv%0d_r", i), r_g, tv[i].r);
      chk($sformatf("tv%0d_dz", i), 32'(dz_g), 32'(tv[i].dz));
    end

    // Busy glitch while idle must not produce anything.
    busy_glitch = 1'b1;
    repeat (2) @(negedge clock);
    busy_glitch = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (out_valid || div_start) seen = 1'b1;
    end
    chk("glitch_ignored", 32'(seen), 32'd0);

    // Both requesters valid continuously from reset: strict alternation.
    do_reset();
    m_lat = 3;
    req0_valid = 1'b1; req0_dividend = 32'd100;       req0_divisor = 32'd7;
    req1_valid = 1'b1; req1_dividend = 32'hFFFF_FF9C; req1_divisor = 32'd7;
    nres = 0;
    for (int c = 0; c < 100 && nres < 4; c++) begin
      @(negedge clock);
      if (out_valid) begin
        ids[nres] = int'(out_id); qs[nres] = out_q; rs[nres] = out_r; nres++;
      end
    end
    chk("alt_count", 32'(nres), 32'd4);
    for (int i = 0; i < nres; i++) begin
      chk($sformatf("alt%0d_id", i), 32'(ids[i]), 32'(i % 2));
      chk($sformatf("alt%0d_q", i), qs[i], (i % 2 == 0) ? 32'd14 : 32'hFFFF_FFF2);
      chk($sformatf("alt%0d_r", i), rs[i], (i % 2 == 0) ? 32'd2 : 32'hFFFF_FFFE);
    end

    // Reset asserted while the divider is running.
    do_reset();
    m_lat = 8;
    req1_valid = 1'b1; req1_dividend = 32'd50; req1_divisor = 32'd5;
    #1;
    chk("mid_accept", 32'(req1_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    req1_valid = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_out_id", 32'(out_id), 32'd0);
    chk("mid_div_start", 32'(div_start), 32'd0);
    chk("mid_div_dividend", div_dividend, 32'd0);
    chk("mid_div_divisor", div_divisor, 32'd0);
    chk("mid_div_reset", 32'(div_reset), 32'd1);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    reset = 1'b1; tb_last = 1'b1;
    repeat (15) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_no_result", 32'(seen), 32'd0);
    run_txn(1'b1, 1'b0, 32'd9, 32'd3, 32'd0, 32'd0, 2, 1'b0, id_g, q_g, r_g, dz_g);
    tb_last = 1'b0;
    chk("post_rst_id", 32'(id_g), 32'd0);
    chk("post_rst_q", q_g, 32'd3);
    chk("post_rst_r", r_g, 32'd0);
    chk("post_rst_dz", 32'(dz_g), 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      bit v0, v1, pw; int sel, t; logic [31:0] a0, b0, a1, b1;
      sel = int'($urandom_range(0, 2));
      v0 = (sel != 1); v1 = (sel != 0);
      a0 = $urandom; a1 = $urandom;
      t = int'($urandom_range(0, 2));
      b0 = (t == 0) ? 32'd0 : (t == 1) ? 32'(int'($urandom_range(0, 31)) - 16) : $urandom;
      t = int'($urandom_range(0, 2));
      b1 = (t == 0) ? 32'd0 : (t == 1) ? 32'(int'($urandom_range(0, 31)) - 16) : $urandom;
      if (a0 == 32'h8000_0000 && b0 == 32'hFFFF_FFFF) b0 = 32'd1;
      if (a1 == 32'h8000_0000 && b1 == 32'hFFFF_FFFF) b1 = 32'd1;
      pw = (v0 && v1) ? ~tb_last : v1;
      ref_div(pw ? a1 : a0, pw ? b1 : b0, eq, er, edz);
      run_txn(v0, v1, a0, b0, a1, b1, int'($urandom_range(1, 6)), pw, id_g, q_g, r_g, dz_g);
      tb_last = pw;
      chk($sformatf("rnd%0d_id", i), 32'(id_g), 32'(pw));
      chk($sformatf("rnd%0d_q", i), q_g, eq);
      chk($sformatf("rnd%0d_r", i), r_g, er);
      chk($sformatf("rnd%0d_dz", i), 32'(dz_g), 32'(edz));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_share_ctrl.md
# div_share_ctrl

Controller that shares the single iterative signed divider (`DIV`) between two requesters, such as the CPU execute stage and a coprocessor port. It performs round-robin arbitration, latches the winning operands, and drives the divider's `start`/`busy` sequence. It short-circuits divide-by-zero without launching the divider, then returns quotient and remainder on a shared, tagged result bus. It sits between the requesters and one `DIV` instance.

## Interface
- `WIDTH`, 32, operand/result width (must match `DIV`)
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `req0_valid`, `req1_valid`  in  1  requester has a division pending
- `req0_dividend`, `req1_dividend`  in  WIDTH  signed dividend
- `req0_divisor`, `req1_divisor`  in  WIDTH  signed divisor
- `req0_ready`, `req1_ready`  out  1  accept; transfer when valid&ready on a rising edge
- `out_valid`  out  1  one-cycle result pulse
- `out_id`  out  1  requester the result belongs to (0/1)
- `out_q`, `out_r`  out  WIDTH  quotient / remainder
- `out_dz`  out  1  result is a divide-by-zero substitute
- `div_reset`  out  1  active-high reset to `DIV`, = ~`reset`
- `div_start`  out  1  one-cycle start to `DIV`
- `div_dividend`, `div_divisor`  out  WIDTH  latched operands to `DIV`
- `div_busy`  in  1  `DIV` busy
- `div_q`, `div_r`  in  WIDTH  `DIV` results, valid once busy falls

## Operation
- States: IDLE, START, WAIT_BUSY, RUN, DONE.
- IDLE: the grant is combinational. If exactly one request is valid, it is granted. If both are valid, the requester other than `last_grant` is granted. `reqN_ready` = (state==IDLE) & grantN. Only one ready is high at a time, and ready never asserts outside IDLE.
- Accept edge: the winner's operands are latched into `div_dividend`/`div_divisor`, `last_grant` ← winner, and the id register ← winner.
  - Divisor == 0: go to DONE with `out_q`=all ones, `out_r`=dividend, `out_dz`=1. The divider is not started.
  - Divisor != 0: go to START.
- START: `div_start`=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: hold until `div_busy`=1 is sampled, then go to RUN.
- RUN: hold while `div_busy`=1. On the edge sampling `div_busy`=0, register `div_q`→`out_q`, `div_r`→`out_r`, and `out_dz`=0, then go to DONE.
- DONE: `out_valid`=1 for one cycle with `out_id`, then return to IDLE. A new request can be accepted in the following IDLE cycle.
- `div_dividend`/`div_divisor` are held stable from the accept edge until the next accept.
- `out_q`/`out_r`/`out_dz`/`out_id` hold their last values after DONE. They are only meaningful while `out_valid`=1.
- Arithmetic is the `DIV` signed convention: the quotient truncates toward zero, and the remainder takes the sign of the dividend. The controller does no arithmetic beyond the zero check.

## Timing
- Reset (asynchronous, `reset`=0):
  - state=IDLE, `last_grant`=1 (req0 wins the first tie).
  - All outputs are 0: `reqN_ready`, `out_valid`, `out_id`, `out_q`, `out_r`, `out_dz`, `div_start`, `div_dividend`, `div_divisor`.
  - `div_reset`=1.
- Reset mid-operation: the controller aborts immediately to IDLE, no `out_valid` is issued, and the divider is reset via `div_reset`. The in-flight request is lost, and the requester must reissue it.
- Latency, divisor != 0: the accept edge is edge 0. `div_start` is high in cycle 1. If the divider holds busy for B cycles, `out_valid` is high in cycle 3+B (assuming busy rises the cycle after start).
- Latency, divisor == 0: `out_valid` is high in cycle 1 after the accept edge.
- Throughput: at most one division in flight. Minimum request spacing is latency+1 cycles.
- A requester may drop `valid` before acceptance without penalty. Operands are sampled only on the accept edge.
- `div_busy` glitches outside WAIT_BUSY/RUN are ignored.

## Test plan
- Single req0, 7 / -2 (0xFFFFFFFE) → one `div_start` pulse; `out_valid` with `out_id`=0, `out_q`=0xFFFFFFFD, `out_r`=1, `out_dz`=0; `req1_ready` never high.
- Single req1, -7 / -2 → `out_id`=1, `out_q`=3, `out_r`=0xFFFFFFFF.
- Both valid continuously from reset (req0: 100/7, req1: -100/7) → req0 served first (q=14, r=2), then req1 (q=0xFFFFFFF2, r=0xFFFFFFFE), then req0 again. Grants alternate strictly.
- req0 with divisor 0, dividend 0x12345678 → no `div_start`; `out_valid` one cycle after accept with `out_q`=0xFFFFFFFF, `out_r`=0x12345678, `out_dz`=1.
- Assert `reset`=0 while in RUN → all outputs go to 0 asynchronously, `div_reset`=1, and no `out_valid`. After release, a new 9/3 request returns q=3, r=0.
- Check `div_start` is never high for more than one cycle, and `div_dividend`/`div_divisor` never change between accept and DONE.
